uart_tx_mmio: RTL

- Memory-mapped UART transmitter peripheral for the DE1-SoC environment.
- Sits directly downstream of memory_map. memory_map decodes the core's data-bus address into this block's 16-byte window and forwards the bus signals.
- Core stores bytes into an internal FIFO; the block serialises them 8N1 on uart_tx at a programmable baud divisor. Core polls status through the same bus.

---
 rtl/uart_tx_mmio_if.sv | 10 +
 rtl/uart_tx_mmio.sv | 130 +++++++++++++
 2 files changed

// File: rtl/uart_tx_mmio_if.sv
// uart_tx_mmio_if: memory_map-to-UART bus; master drives select/address/write_data/write_enable, slave returns registered read_data
interface uart_tx_mmio_if;
   logic        select;
   logic [31:0] address;
   logic [31:0] write_data;
   logic [3:0]  write_enable;
   logic [31:0] read_data;
   modport master (output select, address, write_data, write_enable, input read_data);
   modport slave (input select, address, write_data, write_enable, output read_data);
endinterface

// File: rtl/uart_tx_mmio.sv
// uart_tx_mmio: MMIO 8N1 UART transmitter with TX FIFO; ports clk, reset (async high), bus (slave: select/address/write_data/write_enable/read_data), uart_tx (idle high), irq_empty
module uart_tx_mmio #(
   parameter int FIFO_DEPTH      = 8,
   parameter int DEFAULT_DIVISOR = 434,
   parameter int DIV_WIDTH       = 16
) (
   input  logic          clk,
   input  logic          reset,
   uart_tx_mmio_if.slave bus,
   output logic          uart_tx,
   output logic          irq_empty
);
   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int CW = PW + 1;
   localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);
   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
   state_t               state_q, state_d;
   logic [7:0]           mem_q [FIFO_DEPTH];
   logic [7:0]           mem_d [FIFO_DEPTH];
   logic [PW-1:0]        wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]        count_q, count_d;
   logic                 overflow_q, overflow_d;
   logic [DIV_WIDTH-1:0] div_q, div_d, div_lat_q, div_lat_d, cnt_q, cnt_d;
   logic [2:0]           idx_q, idx_d;
   logic [7:0]           byte_q, byte_d;
   logic [31:0]          read_data_q, read_data_d;
   logic                 irq_q, irq_d;
   logic [31:0]          div_wr;
   logic [1:0]           reg_sel;
   logic                 push_req, push_ok, full, empty, pop, bit_end, unused_ok;
   assign reg_sel   = bus.address[3:2];
   assign full      = count_q == FULL_CNT;
   assign empty     = count_q == '0;
   assign push_req  = bus.select && reg_sel == 2'd0 && bus.write_enable[0];
   assign push_ok   = push_req && !full;
   assign pop       = state_q == IDLE && !empty;
   assign bit_end   = cnt_q == div_lat_q - DIV_WIDTH'(1);
   assign uart_tx   = state_q == START ? 1'b0 : state_q == DATA ? byte_q[idx_q] : 1'b1;
   assign irq_empty = irq_q;
   assign bus.read_data = read_data_q;
   assign unused_ok = ^{bus.address[31:4], bus.address[1:0], div_wr};
   always_comb begin
      mem_d      = mem_q;
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      overflow_d = overflow_q;
      if (push_ok) begin
         mem_d[wr_ptr_q] = bus.write_data[7:0];
         wr_ptr_d        = wr_ptr_q + PW'(1);
      end
      if (push_req && full)
         overflow_d = 1'b1;
      if (bus.select && reg_sel == 2'd1 && bus.write_enable[0] && bus.write_data[3])
         overflow_d = 1'b0;
      if (pop)
         rd_ptr_d = rd_ptr_q + PW'(1);
      count_d = count_q + CW'(push_ok) - CW'(pop);
      div_wr  = 32'(div_q);
      for (int b = 0; b < 4; b++)
         if (bus.write_enable[b])
            div_wr[8*b +: 8] = bus.write_data[8*b +: 8];
      div_d = div_q;
      if (bus.select && reg_sel == 2'd2 && |bus.write_enable)
         div_d = div_wr[DIV_WIDTH-1:0] < DIV_WIDTH'(2) ? DIV_WIDTH'(2) : div_wr[DIV_WIDTH-1:0];
      read_data_d = '0;
      if (bus.select)
         read_data_d = reg_sel == 2'd1 ? {21'd0, 7'(count_q), overflow_q, state_q != IDLE, empty, full}
                     : reg_sel == 2'd2 ? 32'(div_q) : '0;
      irq_d = empty && state_q == IDLE;
   end
   // Divisor is latched per frame so mid-frame divisor writes only affect the next frame.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      idx_d     = idx_q;
      byte_d    = byte_q;
      div_lat_d = div_lat_q;
      if (state_q == IDLE) begin
         if (!empty) begin
            byte_d    = mem_q[rd_ptr_q];
            div_lat_d = div_q;
            cnt_d     = '0;
            state_d   = START;
         end
      end else if (bit_end) begin
         cnt_d = '0;
         if (state_q == START) begin
            state_d = DATA;
            idx_d   = '0;
         end else if (state_q == DATA) begin
            idx_d = idx_q + 3'd1;
            if (idx_q == 3'd7)
               state_d = STOP;
         end else
            state_d = IDLE;
      end else
         cnt_d = cnt_q + DIV_WIDTH'(1);
   end
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= IDLE;
         mem_q       <= '{default: '0};
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         overflow_q  <= 1'b0;
         div_q       <= DIV_WIDTH'(DEFAULT_DIVISOR);
         div_lat_q   <= DIV_WIDTH'(DEFAULT_DIVISOR);
         cnt_q       <= '0;
         idx_q       <= '0;
         byte_q      <= '0;
         read_data_q <= '0;
         irq_q       <= 1'b1;
      end else begin
         state_q     <= state_d;
         mem_q       <= mem_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
         overflow_q  <= overflow_d;
         div_q       <= div_d;
         div_lat_q   <= div_lat_d;
         cnt_q       <= cnt_d;
         idx_q       <= idx_d;
         byte_q      <= byte_d;
         read_data_q <= read_data_d;
         irq_q       <= irq_d;
      end
   end
endmodule
